// File: rtl/costas_carrier_nco.sv
// rtl/costas_carrier_nco.sv - Costas loop local carrier NCO with epoch timer and Doppler cycle count
module costas_carrier_nco #(
  parameter int LOCAL_CARRIER_NCO_PHASE_WIDTH = 40,
  parameter int NCO_OUTPUT_PHASE_WIDTH        = 16,
  parameter int EPOCH_CYCLES                  = 100000
) (
  input  logic                                     iw_Clk_p_g,
  input  logic                                     iw_Rst_h_g,
  input  logic                                     iw_Nco_Enable_h,
  input  logic                                     iw_Nco_Restart_h,
  input  logic [LOCAL_CARRIER_NCO_PHASE_WIDTH-1:0] iw_Carrier_Nominal,
  input  logic                                     iw_Carrier_Loop_Output_Valid,
  input  logic [LOCAL_CARRIER_NCO_PHASE_WIDTH-1:0] iw_Carrier_Loop_Output,
  output logic [NCO_OUTPUT_PHASE_WIDTH-1:0]        ow_Nco_Phase,
  output logic                                     ow_Nco_Phase_Valid,
  output logic                                     ow_Epoch_h,
  output logic [LOCAL_CARRIER_NCO_PHASE_WIDTH-1:0] ow_Freq_Word,
  output logic                                     ow_Update_Pending,
  output logic [31:0]                              ow_Carrier_Cycles
);

  localparam int W  = LOCAL_CARRIER_NCO_PHASE_WIDTH;
  localparam int N  = NCO_OUTPUT_PHASE_WIDTH;
  localparam int CW = (EPOCH_CYCLES > 2) ? $clog2(EPOCH_CYCLES) : 1;
  localparam logic [CW-1:0] EPOCH_LAST = CW'(EPOCH_CYCLES - 1);

  logic [W-1:0]  phase_q;
  logic [CW-1:0] epoch_cnt_q;
  logic [31:0]   cycle_cnt_q;
  logic [W-1:0]  pending_q;

  logic [W:0]    sum;
  logic          carry;
  logic          epoch_end;
  logic [W-1:0]  corr_sel;
  logic          apply_corr;
  logic [32:0]   cyc_sum;
  logic [31:0]   cyc_next;

  // Phase step, epoch detection, correction selection and saturating overflow count
  always_comb begin
    sum        = {1'b0, phase_q} + {1'b0, ow_Freq_Word};
    carry      = sum[W];
    epoch_end  = iw_Nco_Enable_h && (epoch_cnt_q == EPOCH_LAST);
    corr_sel   = iw_Carrier_Loop_Output_Valid ? iw_Carrier_Loop_Output : pending_q;
    apply_corr = epoch_end && (iw_Carrier_Loop_Output_Valid || ow_Update_Pending);
    cyc_sum    = {1'b0, cycle_cnt_q} + 33'(carry);
    cyc_next   = cyc_sum[32] ? 32'hFFFF_FFFF : cyc_sum[31:0];
  end

  // Phase accumulator, epoch timer, overflow counter and DDS phase output
  always_ff @(posedge iw_Clk_p_g or posedge iw_Rst_h_g) begin
    if (iw_Rst_h_g) begin
      phase_q            <= '0;
      epoch_cnt_q        <= '0;
      cycle_cnt_q        <= '0;
      ow_Nco_Phase       <= '0;
      ow_Nco_Phase_Valid <= 1'b0;
      ow_Epoch_h         <= 1'b0;
      ow_Carrier_Cycles  <= '0;
    end else if (iw_Nco_Restart_h) begin
      phase_q            <= '0;
      epoch_cnt_q        <= '0;
      cycle_cnt_q        <= '0;
      ow_Nco_Phase_Valid <= 1'b0;
      ow_Epoch_h         <= 1'b0;
      ow_Carrier_Cycles  <= '0;
    end else if (iw_Nco_Enable_h) begin
      phase_q            <= sum[W-1:0];
      ow_Nco_Phase       <= phase_q[W-1 -: N];
      ow_Nco_Phase_Valid <= 1'b1;
      ow_Epoch_h         <= epoch_end;
      if (epoch_end) begin
        epoch_cnt_q       <= '0;
        ow_Carrier_Cycles <= cyc_next;
        cycle_cnt_q       <= '0;
      end else begin
        epoch_cnt_q       <= epoch_cnt_q + CW'(1);
        cycle_cnt_q       <= cyc_next;
      end
    end else begin
      ow_Nco_Phase_Valid <= 1'b0;
      ow_Epoch_h         <= 1'b0;
    end
  end

  // Correction latch and epoch-aligned frequency word update
  always_ff @(posedge iw_Clk_p_g or posedge iw_Rst_h_g) begin
    if (iw_Rst_h_g) begin
      pending_q         <= '0;
      ow_Update_Pending <= 1'b0;
      ow_Freq_Word      <= '0;
    end else if (iw_Nco_Restart_h) begin
      pending_q         <= '0;
      ow_Update_Pending <= 1'b0;
      ow_Freq_Word      <= iw_Carrier_Nominal;
    end else if (apply_corr) begin
      ow_Freq_Word      <= iw_Carrier_Nominal + corr_sel;
      ow_Update_Pending <= 1'b0;
    end else if (iw_Carrier_Loop_Output_Valid) begin
      pending_q         <= iw_Carrier_Loop_Output;
      ow_Update_Pending <= 1'b1;
    end
  end

endmodule

// File: tb/tb_costas_carrier_nco.sv
// tb/tb_costas_carrier_nco.sv - Scoreboard bench for costas_carrier_nco
module tb_costas_carrier_nco;

  localparam int W     = 40;
  localparam int N     = 16;
  localparam int EPOCH = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic          rs = 1'b0;
  logic          v = 1'b0;
  logic [W-1:0]  corr = '0;
  logic [W-1:0]  nom = '0;

  logic [N-1:0]  nco_phase;
  logic          nco_valid;
  logic          epoch;
  logic [W-1:0]  freq;
  logic          upd_pend;
  logic [31:0]   cycles;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [N-1:0] nco;
    logic         nvalid;
    logic         epoch;
    logic [W-1:0] freq;
    logic         pend;
    logic [31:0]  cycles;
  } exp_t;

  exp_t sb[$];

  logic [W-1:0]  m_phase = '0;
  logic [W-1:0]  m_freq = '0;
  logic [W-1:0]  m_pend_val = '0;
  int            m_cnt = 0;
  logic [31:0]   m_cyc = '0;
  logic [31:0]   m_cycles = '0;
  logic          m_pend = 1'b0;
  logic          m_nvalid = 1'b0;
  logic          m_epoch = 1'b0;
  logic [N-1:0]  m_nco = '0;

  costas_carrier_nco #(
    .LOCAL_CARRIER_NCO_PHASE_WIDTH(W),
    .NCO_OUTPUT_PHASE_WIDTH(N),
    .EPOCH_CYCLES(EPOCH)
  ) dut (
    .iw_Clk_p_g(clk),
    .iw_Rst_h_g(rst),
    .iw_Nco_Enable_h(en),
    .iw_Nco_Restart_h(rs),
    .iw_Carrier_Nominal(nom),
    .iw_Carrier_Loop_Output_Valid(v),
    .iw_Carrier_Loop_Output(corr),
    .ow_Nco_Phase(nco_phase),
    .ow_Nco_Phase_Valid(nco_valid),
    .ow_Epoch_h(epoch),
    .ow_Freq_Word(freq),
    .ow_Update_Pending(upd_pend),
    .ow_Carrier_Cycles(cycles)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = '0; m_freq = '0; m_pend_val = '0; m_cnt = 0; m_cyc = '0;
    m_cycles = '0; m_pend = 1'b0; m_nvalid = 1'b0; m_epoch = 1'b0; m_nco = '0;
  endtask

  // Reference model: computes the outputs expected after the coming clock edge
  task automatic model_step();
    exp_t e;
    logic [W:0]  s;
    logic [32:0] c;
    logic        last;
    if (rs) begin
      m_phase = '0; m_cnt = 0; m_cyc = '0; m_pend_val = '0; m_pend = 1'b0;
      m_nvalid = 1'b0; m_epoch = 1'b0; m_cycles = '0; m_freq = nom;
    end else begin
      last = en && (m_cnt == EPOCH - 1);
      if (en) begin
        s = {1'b0, m_phase} + {1'b0, m_freq};
        m_nco = m_phase[W-1:W-N];
        m_phase = s[W-1:0];
        c = {1'b0, m_cyc} + 33'(s[W]);
        if (c[32]) c = 33'h0_FFFF_FFFF;
        if (last) begin
          m_cycles = c[31:0];
          m_cyc = '0;
          m_cnt = 0;
        end else begin
          m_cyc = c[31:0];
          m_cnt++;
        end
        m_nvalid = 1'b1;
        m_epoch = last;
      end else begin
        m_nvalid = 1'b0;
        m_epoch = 1'b0;
      end
      if (last && (v || m_pend)) begin
        m_freq = nom + (v ? corr : m_pend_val);
        m_pend = 1'b0;
      end else if (v) begin
        m_pend_val = corr;
        m_pend = 1'b1;
      end
    end
    e.nco = m_nco; e.nvalid = m_nvalid; e.epoch = m_epoch;
    e.freq = m_freq; e.pend = m_pend; e.cycles = m_cycles;
    sb.push_back(e);
  endtask

  // One clock: push expectation, clock, compare DUT against the popped entry
  task automatic cycle();
    exp_t e;
    model_step();
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check("sb_empty", 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      check("nco_phase", 64'(nco_phase), 64'(e.nco));
      check("nco_valid", 64'(nco_valid), 64'(e.nvalid));
      check("epoch", 64'(epoch), 64'(e.epoch));
      check("freq_word", 64'(freq), 64'(e.freq));
      check("upd_pend", 64'(upd_pend), 64'(e.pend));
      check("car_cycles", 64'(cycles), 64'(e.cycles));
    end
    v = 1'b0;
    rs = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_phase"}, 64'(nco_phase), 64'd0);
    check({tag, "_valid"}, 64'(nco_valid), 64'd0);
    check({tag, "_epoch"}, 64'(epoch), 64'd0);
    check({tag, "_freq"}, 64'(freq), 64'd0);
    check({tag, "_pend"}, 64'(upd_pend), 64'd0);
    check({tag, "_cycles"}, 64'(cycles), 64'd0);
  endtask

  task automatic restart_with(input logic [W-1:0] nominal);
    nom = nominal;
    rs = 1'b1;
    en = 1'b0;
    cycle();
  endtask

  initial begin
    // Reset state
    @(posedge clk);
    #1;
    check_all_zero("rst");
    rst = 1'b0;
    model_reset();

    // Nominal 2^36: phase ramps by 0x1000, one overflow per 16-clock epoch
    restart_with(40'h10_0000_0000);
    check("restart_freq", 64'(freq), 64'h10_0000_0000);
    en = 1'b1;
    for (int k = 0; k < EPOCH; k++) begin
      cycle();
      check("ramp_seq", 64'(nco_phase), 64'(16'(k * 16'h1000)));
    end
    check("ramp_epoch", 64'(epoch), 64'd1);
    check("ramp_cycles", 64'(cycles), 64'd1);
    cycle();
    check("ramp_wrap", 64'(nco_phase), 64'h0000);
    check("ramp_epoch_off", 64'(epoch), 64'd0);
    for (int k = 0; k < EPOCH - 1; k++) cycle();
    check("ramp_epoch2", 64'(epoch), 64'd1);
    check("ramp_cycles2", 64'(cycles), 64'd1);

    // Correction 2^36 strobed at count 5 doubles the word at the epoch
    for (int i = 0; i < 40 && m_cnt != 5; i++) cycle();
    v = 1'b1;
    corr = 40'h10_0000_0000;
    cycle();
    check("corr_pend", 64'(upd_pend), 64'd1);
    check("corr_hold", 64'(freq), 64'h10_0000_0000);
    for (int i = 0; i < 40 && m_cnt != 0; i++) cycle();
    check("corr_applied", 64'(freq), 64'h20_0000_0000);
    check("corr_pend_clr", 64'(upd_pend), 64'd0);
    for (int k = 0; k < EPOCH; k++) cycle();
    check("corr_cycles", 64'(cycles), 64'd2);

    // Two strobes, then a third coincident with the epoch end wins
    restart_with(40'h10_0000_0000);
    en = 1'b1;
    cycle(); cycle();
    v = 1'b1; corr = 40'h00_0000_0005; cycle();
    cycle();
    v = 1'b1; corr = 40'h00_0000_0007; cycle();
    for (int i = 0; i < 40 && m_cnt != EPOCH - 1; i++) cycle();
    v = 1'b1; corr = 40'h08_0000_0000; cycle();
    check("third_wins", 64'(freq), 64'h18_0000_0000);
    check("third_pend", 64'(upd_pend), 64'd0);

    // Negative correction cancels nominal: word 0 freezes phase
    restart_with(40'h10_0000_0000);
    en = 1'b1;
    v = 1'b1; corr = 40'hF0_0000_0000; cycle();
    for (int i = 0; i < 40 && m_cnt != 0; i++) cycle();
    check("neg_freq", 64'(freq), 64'd0);
    for (int k = 0; k < EPOCH; k++) cycle();
    check("neg_cycles", 64'(cycles), 64'd0);
    check("neg_frozen", 64'(nco_phase), 64'h0000);

    // Enable toggling 1,0,0,1 then restart at count 9 with a correction pending
    restart_with(40'h10_0000_0000);
    for (int r = 0; r < 6; r++) begin
      en = 1'b1; cycle();
      en = 1'b0; cycle(); cycle();
      en = 1'b1; cycle();
    end
    en = 1'b1;
    for (int i = 0; i < 40 && m_cnt != 8; i++) cycle();
    v = 1'b1; corr = 40'h00_0000_0123; cycle();
    check("rs_pend_set", 64'(upd_pend), 64'd1);
    rs = 1'b1; cycle();
    check("rs_pend_clr", 64'(upd_pend), 64'd0);
    check("rs_freq", 64'(freq), 64'h10_0000_0000);
    for (int k = 0; k < EPOCH - 1; k++) cycle();
    check("rs_no_epoch", 64'(epoch), 64'd0);
    cycle();
    check("rs_epoch16", 64'(epoch), 64'd1);
    check("rs_freq_kept", 64'(freq), 64'h10_0000_0000);

    // Randomised traffic against the model
    for (int i = 0; i < 400; i++) begin
      en   = ($urandom_range(0, 3) != 0);
      v    = ($urandom_range(0, 5) == 0);
      corr = {8'($urandom_range(0, 255)), 32'($urandom)};
      if (($urandom_range(0, 63)) == 0) begin
        rs  = 1'b1;
        nom = {8'($urandom_range(0, 255)), 32'($urandom)};
      end
      cycle();
    end

    // Asynchronous reset between edges, then restart
    #3;
    rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    restart_with(40'h10_0000_0000);
    check("post_rst_freq", 64'(freq), 64'h10_0000_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/costas_carrier_nco.md
Name: costas_carrier_nco

Overview:
Local carrier NCO that closes the Costas carrier loop.
- Consumes the frequency correction word and valid strobe produced by the carrier loop filter.
- Adds the correction to a nominal IF frequency word and accumulates carrier phase.
- Emits a truncated phase word for the sin/cos DDS IP, an integration-epoch strobe that paces the correlator dump and loop update, and a per-epoch carrier cycle count for Doppler measurement.

Parameters:
LOCAL_CARRIER_NCO_PHASE_WIDTH, 40, accumulator / frequency word width.
NCO_OUTPUT_PHASE_WIDTH, 16, phase word width fed to DDS IP (MSBs of accumulator).
EPOCH_CYCLES, 100000, enabled clocks per integration epoch (1 ms at 100 MHz); must be >= 2.

Ports:
iw_Clk_p_g  in  1  system clock.
iw_Rst_h_g  in  1  asynchronous reset, active-high.
iw_Nco_Enable_h  in  1  advance NCO and epoch timer this cycle.
iw_Nco_Restart_h  in  1  synchronous restart; same semantics as the loop filter rework strobe.
iw_Carrier_Nominal  in  LOCAL_CARRIER_NCO_PHASE_WIDTH  unsigned nominal IF frequency word.
iw_Carrier_Loop_Output_Valid  in  1  one-cycle strobe for a new correction.
iw_Carrier_Loop_Output  in  LOCAL_CARRIER_NCO_PHASE_WIDTH  two's-complement frequency correction.
ow_Nco_Phase  out  NCO_OUTPUT_PHASE_WIDTH  phase to DDS.
ow_Nco_Phase_Valid  out  1  ow_Nco_Phase valid.
ow_Epoch_h  out  1  one-cycle epoch-end strobe.
ow_Freq_Word  out  LOCAL_CARRIER_NCO_PHASE_WIDTH  frequency word currently applied.
ow_Update_Pending  out  1  correction latched, not yet applied.
ow_Carrier_Cycles  out  32  accumulator overflows counted in the last completed epoch.

Behaviour:
Reset (async, iw_Rst_h_g=1): all registers and outputs 0. ow_Freq_Word=0.

Priority: reset > restart > epoch update / latching > accumulate.

Restart (iw_Nco_Restart_h=1):
- Phase, epoch counter, cycle counter, pending register, ow_Update_Pending, ow_Nco_Phase_Valid, ow_Epoch_h and ow_Carrier_Cycles all go to 0.
- ow_Freq_Word <= iw_Carrier_Nominal.
- Any strobe arriving in the same cycle is discarded.

Correction latch (any cycle, independent of enable):
- On iw_Carrier_Loop_Output_Valid: pending <= iw_Carrier_Loop_Output, ow_Update_Pending <= 1.
- A later strobe before the epoch overwrites the pending value.

Enabled cycle (iw_Nco_Enable_h=1):
- sum = {1'b0, phase} + {1'b0, ow_Freq_Word}. This is a width+1 unsigned add.
- phase <= sum[W-1:0]; carry = sum[W].
- ow_Nco_Phase <= phase[W-1 -: NCO_OUTPUT_PHASE_WIDTH], i.e. the pre-add value, registered. Latency is 1 clock.
- ow_Nco_Phase_Valid <= 1.
- The epoch counter counts 0..EPOCH_CYCLES-1 and wraps.

Epoch-end cycle (enabled and counter == EPOCH_CYCLES-1):
- ow_Epoch_h <= 1, visible the next clock for exactly one clock.
- ow_Carrier_Cycles <= cycle_cnt + carry, then cycle_cnt <= 0. Otherwise cycle_cnt += carry, saturating at 2^32-1.
- If pending or valid this cycle: ow_Freq_Word <= iw_Carrier_Nominal + correction, modulo 2^W, and ow_Update_Pending <= 0.
  - A coincident strobe's value takes precedence over the pending value.
  - The new word takes effect from the next enabled cycle, so phase stays continuous and the frequency is constant within an epoch.
- With no correction, ow_Freq_Word is unchanged. iw_Carrier_Nominal is sampled only at restart and at epoch updates.

Disabled cycle:
- phase, counters and ow_Freq_Word hold.
- ow_Nco_Phase holds its value; ow_Nco_Phase_Valid <= 0; ow_Epoch_h <= 0.

Frequency word behaviour:
- A negative correction yields a wrapped unsigned word. No saturation is applied.
- A word of 0 freezes phase.

Test Plan:
- Reset mid-run: assert iw_Rst_h_g asynchronously between clock edges -> all outputs 0 immediately. After release plus a restart with nominal 0x10_0000_0000, ow_Freq_Word=0x10_0000_0000.
- Nominal 2^36, EPOCH_CYCLES=16, enable always -> ow_Nco_Phase sequence 0x0000,0x1000,...,0xF000,0x0000. ow_Epoch_h pulses every 16 clocks. ow_Carrier_Cycles=1 after each epoch.
- Correction 2^36 strobed at epoch count 5 -> ow_Update_Pending=1 for counts 6..15. ow_Freq_Word stays 2^36 until the epoch, then becomes 2^37. The next epoch reports ow_Carrier_Cycles=2.
- Two strobes in one epoch, then a third coincident with the epoch-end cycle -> only the third value is applied.
- Correction -2^36 (0xF0_0000_0000) on nominal 2^36 -> ow_Freq_Word=0, phase frozen, ow_Carrier_Cycles=0.
- Enable toggled 1,0,0,1 -> phase and epoch counter hold while disabled, and ow_Nco_Phase_Valid follows the enable delayed by 1. Restart at count 9 -> counter reset, next epoch 16 enabled clocks later, pending cleared.
